systolic_array_axi4_full: RTL and testbench

Instruction-driven AXI4-Full master with a local unified buffer (UB); it moves 128-bit words between off-chip memory and the UB. It is the data-movement front end of the systolic-array accelerator: it accepts one instruction per handshake, executes it as a single-beat AXI transaction, and reports acceptance and activity to the host sequencer. The compute blocks (weight buffer, FIFOs, MMU, accumulators) attach to the UB and are outside this block.

---
 rtl/systolic_array_axi4_full.sv | 260 ++++++++++++++++++++++++++
 tb/tb_systolic_array_axi4_full.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_axi4_full.sv
// systolic_array_axi4_full
// Instruction-driven single-beat AXI4 master that moves 128-bit words between
// off-chip memory and a local unified buffer (UB).
//   instruction[35:32] opcode (1 = AXI_TO_UB, 2 = UB_TO_AXI, others idle)
//   instruction[31:16] ADDRA, instruction[15:0] ADDRB
//   flag      : one-cycle pulse when an instruction has been captured
//   idle_flag : high while no AXI transaction is in progress
//   m00_axi_* : AXI4 master port (AW/W/B/AR/R), IDs and user bits driven 0
// Optional build macro SA_AXI_ERR_CHECK_EN: a non-OKAY rresp/bresp parks the
// FSM in ERROR until reset; otherwise response codes are ignored.
module systolic_array_axi4_full #(
    parameter logic [31:0] C_M00_AXI_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int unsigned C_M00_AXI_ID_WIDTH     = 1,
    parameter int unsigned C_M00_AXI_ADDR_WIDTH   = 32,
    parameter int unsigned C_M00_AXI_DATA_WIDTH   = 128,
    parameter int unsigned C_M00_AXI_AWUSER_WIDTH = 1,
    parameter int unsigned C_M00_AXI_ARUSER_WIDTH = 1,
    parameter int unsigned C_M00_AXI_WUSER_WIDTH  = 1,
    parameter int unsigned C_M00_AXI_RUSER_WIDTH  = 1,
    parameter int unsigned C_M00_AXI_BUSER_WIDTH  = 1,
    parameter int unsigned UB_DEPTH               = 256
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [35:0]                           instruction,
    output logic                                  flag,
    output logic                                  idle_flag,
    // AW channel
    output logic [C_M00_AXI_ID_WIDTH-1:0]         m00_axi_awid,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]       m00_axi_awaddr,
    output logic [7:0]                            m00_axi_awlen,
    output logic [2:0]                            m00_axi_awsize,
    output logic [1:0]                            m00_axi_awburst,
    output logic                                  m00_axi_awlock,
    output logic [3:0]                            m00_axi_awcache,
    output logic [2:0]                            m00_axi_awprot,
    output logic [3:0]                            m00_axi_awqos,
    output logic [C_M00_AXI_AWUSER_WIDTH-1:0]     m00_axi_awuser,
    output logic                                  m00_axi_awvalid,
    input  logic                                  m00_axi_awready,
    // W channel
    output logic [C_M00_AXI_DATA_WIDTH-1:0]       m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0]     m00_axi_wstrb,
    output logic                                  m00_axi_wlast,
    output logic [C_M00_AXI_WUSER_WIDTH-1:0]      m00_axi_wuser,
    output logic                                  m00_axi_wvalid,
    input  logic                                  m00_axi_wready,
    // B channel
    input  logic [C_M00_AXI_ID_WIDTH-1:0]         m00_axi_bid,
    input  logic [1:0]                            m00_axi_bresp,
    input  logic [C_M00_AXI_BUSER_WIDTH-1:0]      m00_axi_buser,
    input  logic                                  m00_axi_bvalid,
    output logic                                  m00_axi_bready,
    // AR channel
    output logic [C_M00_AXI_ID_WIDTH-1:0]         m00_axi_arid,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]       m00_axi_araddr,
    output logic [7:0]                            m00_axi_arlen,
    output logic [2:0]                            m00_axi_arsize,
    output logic [1:0]                            m00_axi_arburst,
    output logic                                  m00_axi_arlock,
    output logic [3:0]                            m00_axi_arcache,
    output logic [2:0]                            m00_axi_arprot,
    output logic [3:0]                            m00_axi_arqos,
    output logic [C_M00_AXI_ARUSER_WIDTH-1:0]     m00_axi_aruser,
    output logic                                  m00_axi_arvalid,
    input  logic                                  m00_axi_arready,
    // R channel
    input  logic [C_M00_AXI_ID_WIDTH-1:0]         m00_axi_rid,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]       m00_axi_rdata,
    input  logic [1:0]                            m00_axi_rresp,
    input  logic                                  m00_axi_rlast,
    input  logic [C_M00_AXI_RUSER_WIDTH-1:0]      m00_axi_ruser,
    input  logic                                  m00_axi_rvalid,
    output logic                                  m00_axi_rready
);

    localparam int unsigned AW    = C_M00_AXI_ADDR_WIDTH;
    localparam int unsigned DW    = C_M00_AXI_DATA_WIDTH;
    localparam int unsigned UB_AW = $clog2(UB_DEPTH);

    typedef enum logic [2:0] {
        ST_FETCH, ST_ACK, ST_AR, ST_R, ST_UBRD, ST_AW, ST_B, ST_ERROR
    } state_t;

    state_t            state, state_nxt;
    logic [35:0]       instr_q;
    logic [DW-1:0]     ub [UB_DEPTH];

    logic              flag_nxt, idle_nxt;
    logic              arvalid_nxt, rready_nxt, awvalid_nxt, wvalid_nxt, bready_nxt;
    logic [AW-1:0]     araddr_nxt, awaddr_nxt;
    logic              ub_we;
    logic              r_resp_ok, b_resp_ok;

    logic [3:0]        opcode;
    logic [15:0]       addr_a, addr_b;
    logic [UB_AW-1:0]  ub_wr_idx, ub_rd_idx;

    assign opcode    = instr_q[35:32];
    assign addr_a    = instr_q[31:16];
    assign addr_b    = instr_q[15:0];
    assign ub_wr_idx = addr_a[UB_AW-1:0];
    assign ub_rd_idx = addr_b[UB_AW-1:0];

`ifdef SA_AXI_ERR_CHECK_EN
    assign r_resp_ok = (m00_axi_rresp == 2'b00);
    assign b_resp_ok = (m00_axi_bresp == 2'b00);
    logic unused_inputs;
    assign unused_inputs = ^{m00_axi_bid, m00_axi_buser, m00_axi_rid,
                             m00_axi_rlast, m00_axi_ruser};
`else
    assign r_resp_ok = 1'b1;
    assign b_resp_ok = 1'b1;
    logic unused_inputs;
    assign unused_inputs = ^{m00_axi_bid, m00_axi_buser, m00_axi_rid,
                             m00_axi_rlast, m00_axi_ruser,
                             m00_axi_rresp, m00_axi_bresp};
`endif

    // Constant single-beat INCR transaction attributes
    assign m00_axi_awid    = '0;
    assign m00_axi_awlen   = 8'd0;
    assign m00_axi_awsize  = 3'b100;
    assign m00_axi_awburst = 2'b01;
    assign m00_axi_awlock  = 1'b0;
    assign m00_axi_awcache = 4'b0010;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awqos   = 4'b0000;
    assign m00_axi_awuser  = '0;
    assign m00_axi_wstrb   = '1;
    assign m00_axi_wlast   = m00_axi_wvalid;
    assign m00_axi_wuser   = '0;
    assign m00_axi_arid    = '0;
    assign m00_axi_arlen   = 8'd0;
    assign m00_axi_arsize  = 3'b100;
    assign m00_axi_arburst = 2'b01;
    assign m00_axi_arlock  = 1'b0;
    assign m00_axi_arcache = 4'b0010;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arqos   = 4'b0000;
    assign m00_axi_aruser  = '0;

    // Next-state and next-output decode; outputs are registered from these
    always_comb begin
        state_nxt   = state;
        arvalid_nxt = m00_axi_arvalid;
        araddr_nxt  = m00_axi_araddr;
        rready_nxt  = m00_axi_rready;
        awvalid_nxt = m00_axi_awvalid;
        awaddr_nxt  = m00_axi_awaddr;
        wvalid_nxt  = m00_axi_wvalid;
        bready_nxt  = m00_axi_bready;
        ub_we       = 1'b0;

        case (state)
            ST_FETCH: state_nxt = ST_ACK;
            ST_ACK: begin
                case (opcode)
                    4'd1: begin
                        state_nxt   = ST_AR;
                        arvalid_nxt = 1'b1;
                        araddr_nxt  = AW'(C_M00_AXI_TARGET_SLAVE_BASE_ADDR)
                                    + AW'({addr_b, 4'b0000});
                    end
                    4'd2:    state_nxt = ST_UBRD;
                    default: state_nxt = ST_FETCH;
                endcase
            end
            ST_AR: begin
                if (m00_axi_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = ST_R;
                end
            end
            ST_R: begin
                if (m00_axi_rvalid) begin
                    rready_nxt = 1'b0;
                    if (r_resp_ok) begin
                        ub_we     = 1'b1;
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_ERROR;
                    end
                end
            end
            ST_UBRD: begin
                awvalid_nxt = 1'b1;
                wvalid_nxt  = 1'b1;
                awaddr_nxt  = AW'(C_M00_AXI_TARGET_SLAVE_BASE_ADDR)
                            + AW'({addr_a, 4'b0000});
                state_nxt   = ST_AW;
            end
            ST_AW: begin
                // AW and W complete independently; leave once both are done
                awvalid_nxt = m00_axi_awvalid & ~m00_axi_awready;
                wvalid_nxt  = m00_axi_wvalid  & ~m00_axi_wready;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    bready_nxt = 1'b1;
                    state_nxt  = ST_B;
                end
            end
            ST_B: begin
                if (m00_axi_bvalid) begin
                    bready_nxt = 1'b0;
                    state_nxt  = b_resp_ok ? ST_FETCH : ST_ERROR;
                end
            end
            ST_ERROR: state_nxt = ST_ERROR;
            default:  state_nxt = ST_FETCH;
        endcase

        flag_nxt = (state_nxt == ST_ACK);
        idle_nxt = (state_nxt == ST_FETCH) || (state_nxt == ST_ACK);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= ST_FETCH;
            instr_q         <= '0;
            flag            <= 1'b0;
            idle_flag       <= 1'b1;
            m00_axi_arvalid <= 1'b0;
            m00_axi_araddr  <= '0;
            m00_axi_rready  <= 1'b0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_awaddr  <= '0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_wdata   <= '0;
            m00_axi_bready  <= 1'b0;
        end else begin
            state           <= state_nxt;
            flag            <= flag_nxt;
            idle_flag       <= idle_nxt;
            m00_axi_arvalid <= arvalid_nxt;
            m00_axi_araddr  <= araddr_nxt;
            m00_axi_rready  <= rready_nxt;
            m00_axi_awvalid <= awvalid_nxt;
            m00_axi_awaddr  <= awaddr_nxt;
            m00_axi_wvalid  <= wvalid_nxt;
            m00_axi_bready  <= bready_nxt;
            if (state == ST_FETCH) begin
                instr_q <= instruction;
            end
            // Registered UB read feeding the write-data channel
            if (state == ST_UBRD) begin
                m00_axi_wdata <= ub[ub_rd_idx];
            end
        end
    end

    // Unified buffer storage (not reset)
    always_ff @(posedge clk) begin
        if (reset_n && ub_we) begin
            ub[ub_wr_idx] <= m00_axi_rdata;
        end
    end

endmodule

// File: tb/tb_systolic_array_axi4_full.sv
module tb_systolic_array_axi4_full;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [127:0] PAT_A5 = 128'hA5A5_A5A5_0123_4567_89AB_CDEF_5A5A_5A5A;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [35:0]  instruction;
    logic         flag, idle_flag;

    logic [0:0]   awid, arid, bid, rid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize, awprot, arprot;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awlock, arlock;
    logic [3:0]   awcache, arcache, awqos, arqos;
    logic [0:0]   awuser, aruser, wuser, buser, ruser;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic         arvalid, arready, rvalid, rready, rlast;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;

    int checks = 0;
    int errors = 0;

    // Slave model state
    logic [127:0] mem [256];
    int           ar_wait = 0, aw_wait = 0, w_wait = 0;
    logic [1:0]   rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    bit           r_go, b_go, aw_got, w_got;
    int           r_idx;
    logic [31:0]  mon_off, aw_addr_q;
    logic [127:0] w_data_q;
    int           ar_hs_cnt = 0, r_hs_cnt = 0, aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0;
    logic [31:0]  last_araddr, last_awaddr;
    logic [7:0]   last_arlen;
    logic [2:0]   last_arsize;
    logic [1:0]   last_arburst;
    logic [3:0]   last_arcache;
    logic [15:0]  last_wstrb;
    logic         last_wlast;
    int           ar_cnt, aw_cnt, w_cnt;
    bit           ar_hold, w_hold, saw_split;
    logic [31:0]  ar_hold_addr;
    logic [127:0] w_hold_data;
    int           stab_err = 0;

    systolic_array_axi4_full dut (
        .clk(clk), .reset_n(reset_n), .instruction(instruction),
        .flag(flag), .idle_flag(idle_flag),
        .m00_axi_awid(awid), .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen),
        .m00_axi_awsize(awsize), .m00_axi_awburst(awburst), .m00_axi_awlock(awlock),
        .m00_axi_awcache(awcache), .m00_axi_awprot(awprot), .m00_axi_awqos(awqos),
        .m00_axi_awuser(awuser), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
        .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
        .m00_axi_wuser(wuser), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
        .m00_axi_bid(bid), .m00_axi_bresp(bresp), .m00_axi_buser(buser),
        .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
        .m00_axi_arid(arid), .m00_axi_araddr(araddr), .m00_axi_arlen(arlen),
        .m00_axi_arsize(arsize), .m00_axi_arburst(arburst), .m00_axi_arlock(arlock),
        .m00_axi_arcache(arcache), .m00_axi_arprot(arprot), .m00_axi_arqos(arqos),
        .m00_axi_aruser(aruser), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rid(rid), .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
        .m00_axi_rlast(rlast), .m00_axi_ruser(ruser), .m00_axi_rvalid(rvalid),
        .m00_axi_rready(rready)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pattern(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(i);
        return {w, ~w, w ^ 32'h5555_5555, 32'(i * 16)};
    endfunction

    // Handshake monitor: samples pre-edge values at the rising edge
    always @(posedge clk) begin
        if (!reset_n) begin
            r_go = 0; b_go = 0; aw_got = 0; w_got = 0;
        end else begin
            if (rvalid && rready) begin r_hs_cnt++; r_go = 0; end
            if (arvalid && arready) begin
                ar_hs_cnt++;
                mon_off = araddr - BASE;
                r_idx = int'(mon_off[11:4]);
                last_araddr = araddr; last_arlen = arlen; last_arsize = arsize;
                last_arburst = arburst; last_arcache = arcache;
                r_go = 1;
            end
            if (bvalid && bready) begin b_hs_cnt++; b_go = 0; end
            if (awvalid && awready) begin
                aw_hs_cnt++; aw_got = 1; aw_addr_q = awaddr; last_awaddr = awaddr;
            end
            if (wvalid && wready) begin
                w_hs_cnt++; w_got = 1; w_data_q = wdata;
                last_wstrb = wstrb; last_wlast = wlast;
            end
            if (aw_got && w_got) begin
                mon_off = aw_addr_q - BASE;
                mem[mon_off[11:4]] = w_data_q;
                aw_got = 0; w_got = 0; b_go = 1;
            end
        end
    end

    // Slave driver: updates ready/valid on the falling edge
    always @(negedge clk) begin
        if (!reset_n) begin
            ar_hold = 0; w_hold = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        end else begin
            if (ar_hold && (!arvalid || araddr != ar_hold_addr)) stab_err++;
            if (w_hold && (!wvalid || wdata != w_hold_data)) stab_err++;
            if (!awvalid && wvalid) saw_split = 1;
            if (arvalid) begin arready = (ar_cnt >= ar_wait); if (!arready) ar_cnt++; end
            else begin arready = 0; ar_cnt = 0; end
            if (awvalid) begin awready = (aw_cnt >= aw_wait); if (!awready) aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_wait); if (!wready) w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
            ar_hold = arvalid && !arready; ar_hold_addr = araddr;
            w_hold  = wvalid && !wready;   w_hold_data  = wdata;
            rvalid = r_go; rdata = r_go ? mem[r_idx] : '0; rresp = rresp_cfg;
            bvalid = b_go; bresp = bresp_cfg;
        end
    end

    // Issue one instruction from FETCH and wait for the return to idle
    task automatic run_instr(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             output int low_cycles, output int flags);
        int n;
        low_cycles = 0; flags = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(idle_flag && !flag) && n < 200);
        instruction = {op, a, b};
        n = 0;
        do begin @(negedge clk); n++; end while (!flag && n < 200);
        flags = 1;
        instruction = '0;
        n = 0;
        forever begin
            @(negedge clk);
            if (flag) flags++;
            if (idle_flag) break;
            low_cycles++;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL run_instr_timeout: op %0d still busy after %0d cycles, required idle", op, n);
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        instruction = '0;
        repeat (3) @(negedge clk);
        checks++; if (flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b want 0", flag); end
        checks++; if (idle_flag !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle_flag); end
        checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
            errors++; $display("FAIL reset_valids: got %b want 00000", {arvalid, awvalid, wvalid, rready, bready}); end
        checks++; if ({araddr, awaddr} !== 64'h0 || wdata !== 128'h0) begin
            errors++; $display("FAIL reset_addr_data: araddr %h awaddr %h wdata %h want 0", araddr, awaddr, wdata); end
    endtask

    task automatic test_idle();
        reset_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (flag !== ((i % 2) == 0)) begin
                errors++; $display("FAIL idle_flag_toggle[%0d]: got %b want %b", i, flag, (i % 2) == 0); end
            checks++; if (idle_flag !== 1'b1 || {arvalid, awvalid, wvalid} !== 3'b0) begin
                errors++; $display("FAIL idle_quiet[%0d]: idle %b valids %b want 1/000", i, idle_flag, {arvalid, awvalid, wvalid}); end
        end
    endtask

    task automatic test_axi_to_ub();
        int low, fl, ar0;
        mem[16] = PAT_A5;
        ar0 = ar_hs_cnt;
        run_instr(4'd1, 16'd3, 16'h0010, low, fl);
        checks++; if (last_araddr !== 32'h4000_0100) begin errors++; $display("FAIL a2u_araddr: got %h want 40000100", last_araddr); end
        checks++; if (last_arlen !== 8'd0 || last_arsize !== 3'd4 || last_arburst !== 2'b01 || last_arcache !== 4'b0010) begin
            errors++; $display("FAIL a2u_attrs: len %0d size %0d burst %b cache %b want 0/4/01/0010", last_arlen, last_arsize, last_arburst, last_arcache); end
        checks++; if (low != 2) begin errors++; $display("FAIL a2u_busy_cycles: got %0d want 2", low); end
        checks++; if (fl != 1) begin errors++; $display("FAIL a2u_flag_pulses: got %0d want 1", fl); end
        checks++; if (ar_hs_cnt - ar0 != 1) begin errors++; $display("FAIL a2u_ar_count: got %0d want 1", ar_hs_cnt - ar0); end
    endtask

    task automatic test_ub_to_axi();
        int low, fl;
        mem[4] = '0;
        run_instr(4'd2, 16'd4, 16'd3, low, fl);
        checks++; if (mem[4] !== PAT_A5) begin errors++; $display("FAIL u2a_data: got %h want %h", mem[4], PAT_A5); end
        checks++; if (last_awaddr !== 32'h4000_0040) begin errors++; $display("FAIL u2a_awaddr: got %h want 40000040", last_awaddr); end
        checks++; if (last_wstrb !== 16'hFFFF || last_wlast !== 1'b1) begin
            errors++; $display("FAIL u2a_wstrb_wlast: got %h/%b want ffff/1", last_wstrb, last_wlast); end
        checks++; if (low != 3) begin errors++; $display("FAIL u2a_busy_cycles: got %0d want 3", low); end
    endtask

    task automatic test_waits();
        int low1, low2, fl;
        int ar0, r0, aw0, w0, b0;
        logic [127:0] v;
        v = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        mem[32] = v; mem[6] = '0;
        ar0 = ar_hs_cnt; r0 = r_hs_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
        stab_err = 0; saw_split = 0;
        ar_wait = 5; w_wait = 3;
        run_instr(4'd1, 16'd5, 16'd32, low1, fl);
        run_instr(4'd2, 16'd6, 16'd5, low2, fl);
        ar_wait = 0; w_wait = 0;
        checks++; if (low1 != 7) begin errors++; $display("FAIL wait_read_cycles: got %0d want 7", low1); end
        checks++; if (low2 != 6) begin errors++; $display("FAIL wait_write_cycles: got %0d want 6", low2); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL wait_stability: got %0d violations want 0", stab_err); end
        checks++; if (saw_split != 1) begin errors++; $display("FAIL wait_aw_drops_first: got %0d want 1", saw_split); end
        checks++; if (mem[6] !== v) begin errors++; $display("FAIL wait_data: got %h want %h", mem[6], v); end
        checks++; if ({ar_hs_cnt - ar0, r_hs_cnt - r0, aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0} !== {5{32'sd1}}) begin
            errors++; $display("FAIL wait_once: ar %0d r %0d aw %0d w %0d b %0d want 1 each",
                ar_hs_cnt - ar0, r_hs_cnt - r0, aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0); end
    endtask

    task automatic test_back_to_back();
        int low, fl;
        for (int i = 0; i < 16; i++) mem[16 * i] = pattern(i);
        for (int i = 0; i < 16; i++) run_instr(4'd1, 16'(i), 16'(16 * i), low, fl);
        for (int i = 0; i < 16; i++) run_instr(4'd2, 16'(64 + i), 16'(i), low, fl);
        for (int i = 0; i < 16; i++) begin
            checks++; if (mem[64 + i] !== pattern(i)) begin
                errors++; $display("FAIL b2b_word[%0d]: got %h want %h", 64 + i, mem[64 + i], pattern(i)); end
        end
    endtask

    task automatic test_reset_abort();
        int n, low, fl;
        n = 0;
        do begin @(negedge clk); n++; end while (!(idle_flag && !flag) && n < 50);
        ar_wait = 20;
        instruction = {4'd1, 16'd7, 16'd48};
        @(negedge clk); instruction = '0;
        @(negedge clk);
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL abort_pre: arvalid %b want 1", arvalid); end
        reset_n = 0;
        @(negedge clk);
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || idle_flag !== 1'b1) begin
            errors++; $display("FAIL abort_drop: arvalid %b rready %b idle %b want 0/0/1", arvalid, rready, idle_flag); end
        @(negedge clk); reset_n = 1; ar_wait = 0;
        run_instr(4'd2, 16'd90, 16'd7, low, fl);
        checks++; if (mem[90] !== pattern(7)) begin errors++; $display("FAIL abort_no_ub_write: got %h want %h", mem[90], pattern(7)); end
    endtask

    task automatic test_bresp_error();
        int n, b0, fl_cnt, idle_cnt;
        n = 0;
        do begin @(negedge clk); n++; end while (!(idle_flag && !flag) && n < 50);
        b0 = b_hs_cnt;
        bresp_cfg = 2'b10;
        instruction = {4'd2, 16'd100, 16'd0};
        @(negedge clk); instruction = '0;
        n = 0;
        while (b_hs_cnt == b0 && n < 50) begin @(negedge clk); n++; end
        checks++; if (b_hs_cnt - b0 != 1) begin errors++; $display("FAIL err_b_handshake: got %0d want 1", b_hs_cnt - b0); end
        fl_cnt = 0; idle_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (flag) fl_cnt++;
            if (idle_flag) idle_cnt++;
        end
`ifdef SA_AXI_ERR_CHECK_EN
        checks++; if (fl_cnt != 0) begin errors++; $display("FAIL err_flag_quiet: got %0d pulses want 0", fl_cnt); end
        checks++; if (idle_cnt != 0) begin errors++; $display("FAIL err_idle_low: got %0d high cycles want 0", idle_cnt); end
`else
        checks++; if (fl_cnt != 5) begin errors++; $display("FAIL noerr_flag_resume: got %0d pulses want 5", fl_cnt); end
        checks++; if (idle_cnt != 10) begin errors++; $display("FAIL noerr_idle: got %0d high cycles want 10", idle_cnt); end
`endif
        bresp_cfg = 2'b00;
        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        checks++; if (flag !== 1'b1 || idle_flag !== 1'b1) begin
            errors++; $display("FAIL err_recover: flag %b idle %b want 1/1", flag, idle_flag); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        bid = '0; rid = '0; buser = '0; ruser = '0; rlast = 1'b1;
        rdata = '0; rresp = 2'b00; bresp = 2'b00;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        test_reset();
        test_idle();
        test_axi_to_ub();
        test_ub_to_axi();
        test_waits();
        test_back_to_back();
        test_reset_abort();
        test_bresp_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
